// File: rtl/hicore_regfile_mp.sv
// rtl/hicore_regfile_mp.sv - multi-port register file with per-register pending bits
// Optional same-cycle writeback-to-read bypass: HICORE_RF_BYPASS_EN.
module hicore_regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    parameter int IDXW = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*IDXW-1:0]  rd_idx,
    output logic [NRD*XLEN-1:0]  rd_dat,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wb_wen,
    input  logic [NWR*IDXW-1:0]  wb_idx,
    input  logic [NWR*XLEN-1:0]  wb_dat,
    input  logic                 iss_wen,
    input  logic [IDXW-1:0]      iss_idx,
    output logic [NREG-1:0]      busy_vec
);

    logic [XLEN-1:0] mem [1:NREG-1];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    // Issue is applied after writeback clears so a newer producer keeps the bit set.
    always_comb begin
        pend_nxt = pend;
        for (int k = 0; k < NWR; k++) begin
            if (wb_wen[k]) begin
                pend_nxt[wb_idx[k*IDXW +: IDXW]] = 1'b0;
            end
        end
        if (iss_wen) begin
            pend_nxt[iss_idx] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                mem[i] <= '0;
            end
            pend <= '0;
        end else begin
            // Later ports overwrite earlier ones, so the highest port wins.
            for (int i = 1; i < NREG; i++) begin
                for (int k = 0; k < NWR; k++) begin
                    if (wb_wen[k] && (wb_idx[k*IDXW +: IDXW] == IDXW'(i))) begin
                        mem[i] <= wb_dat[k*XLEN +: XLEN];
                    end
                end
            end
            pend <= pend_nxt;
        end
    end

    assign busy_vec = pend;

    always_comb begin
        rd_dat  = '0;
        rd_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            for (int i = 1; i < NREG; i++) begin
                if (rd_idx[j*IDXW +: IDXW] == IDXW'(i)) begin
                    rd_dat[j*XLEN +: XLEN] = mem[i];
                end
            end
            rd_busy[j] = pend[rd_idx[j*IDXW +: IDXW]];
`ifdef HICORE_RF_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (wb_wen[k] && (wb_idx[k*IDXW +: IDXW] == rd_idx[j*IDXW +: IDXW]) &&
                    (rd_idx[j*IDXW +: IDXW] != '0)) begin
                    rd_dat[j*XLEN +: XLEN] = wb_dat[k*XLEN +: XLEN];
                    rd_busy[j] = iss_wen && (iss_idx == rd_idx[j*IDXW +: IDXW]);
                end
            end
`endif
        end
    end

endmodule
